// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified memory port arbiter:
//   - state_t : arbiter FSM state encoding (IDLE, ACCESS, RESP)
//   - SEL_IF / SEL_DM : address/write-data mux select values
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Select values for the twoToOneMux instances at the top level.
   localparam logic SEL_IF = 1'b0;  // mux in0
   localparam logic SEL_DM = 1'b1;  // mux in1

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF) and data memory (DM).
// Arbitrates in IDLE, strobes the memory once, waits a fixed LATENCY, then
// pulses the winner's done flag and returns the read data.
//
// Parameters:
//   LATENCY      cycles from mem_en to valid mem_rdata (1..15)
//   STARVE_LIMIT DM wins in a row over a waiting IF before IF is favoured (1..15)
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   if_req        IF read request, held until if_done
//   if_done       one-cycle pulse, IF access complete
//   dm_req/dm_we  DM request and write flag, held until dm_done
//   dm_done       one-cycle pulse, DM access complete
//   mem_sel       mux select: SEL_IF (0) or SEL_DM (1)
//   mem_en/mem_we one-cycle memory strobe and its write enable
//   mem_rdata     memory read data, valid LATENCY cycles after mem_en
//   resp_rdata    read data, valid during the done cycle
//   busy          high in every state except IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned LATENCY      = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   output logic        if_done,
   input  logic        dm_req,
   input  logic        dm_we,
   output logic        dm_done,
   output logic        mem_sel,
   output logic        mem_en,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   output logic [31:0] resp_rdata,
   output logic        busy
);

   localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);
   localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

   state_t      state;
   logic [3:0]  lat_cnt;
   logic [3:0]  streak;
   logic        txn_we;     // current transaction is a DM write
   logic [31:0] resp_q;     // last captured read data

   logic        grant_valid;
   logic        grant_dm;

   // DM normally wins a collision; once it has won STARVE_LIMIT times in a
   // row while IF waited, IF takes the next grant.
   always_comb begin
      grant_valid = if_req | dm_req;
      grant_dm    = dm_req & ~(if_req & (streak == STREAK_MAX));
   end

   // NOTE: every register here is assigned with <= so all of them update
   // from the same pre-edge values; blocking assignments would let later
   // statements see half-updated state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mem_sel <= SEL_IF;
         mem_en  <= 1'b0;
         mem_we  <= 1'b0;
         if_done <= 1'b0;
         dm_done <= 1'b0;
         busy    <= 1'b0;
         lat_cnt <= 4'd0;
         streak  <= 4'd0;
         txn_we  <= 1'b0;
         resp_q  <= 32'h0;
      end else begin
         // Strobes default low so each is a single-cycle pulse.
         mem_en  <= 1'b0;
         mem_we  <= 1'b0;
         if_done <= 1'b0;
         dm_done <= 1'b0;

         case (state)
            IDLE: begin
               // mem_sel holds its last value while nothing is requested.
               if (grant_valid) begin
                  state   <= ACCESS;
                  busy    <= 1'b1;
                  mem_sel <= grant_dm ? SEL_DM : SEL_IF;
                  mem_en  <= 1'b1;
                  mem_we  <= grant_dm & dm_we;
                  txn_we  <= grant_dm & dm_we;
                  lat_cnt <= LAT_LOAD;
                  if (!grant_dm)
                     streak <= 4'd0;
                  else if (if_req && streak != STREAK_MAX)
                     streak <= streak + 4'd1;
               end
            end

            ACCESS: begin
               if (lat_cnt == 4'd0) begin
                  state <= RESP;
                  if (mem_sel == SEL_DM)
                     dm_done <= 1'b1;
                  else
                     if_done <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end

            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (!txn_we)
                  resp_q <= mem_rdata;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // mem_rdata only becomes valid in the done cycle itself, so reads are
   // forwarded straight through during RESP; outside RESP (and for writes)
   // the last captured value is shown.
   always_comb begin
      resp_rdata = resp_q;
      if (state == RESP && !txn_we)
         resp_rdata = mem_rdata;
   end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed testbench for mem_port_arbiter with LATENCY=2, STARVE_LIMIT=4.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic        if_done;
   logic        dm_req;
   logic        dm_we;
   logic        dm_done;
   logic        mem_sel;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic [31:0] resp_rdata;
   logic        busy;

   int n_checks;
   int n_errors;

   mem_port_arbiter #(
      .LATENCY      (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_done    (if_done),
      .dm_req     (dm_req),
      .dm_we      (dm_we),
      .dm_done    (dm_done),
      .mem_sel    (mem_sel),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .resp_rdata (resp_rdata),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; land 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step until mem_en is seen, within a cycle budget.
   task automatic wait_mem_en(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (mem_en) seen = 1'b1;
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
   endtask

   // Step until busy drops, within a cycle budget.
   task automatic wait_idle(input string tag);
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 10 && !idle; i++) begin
         step();
         if (!busy) idle = 1'b1;
      end
      check(tag, 32'(idle), 32'd1);
   endtask

   logic exp_sel [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      int en_cnt;
      int done_cnt;
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      if_req    = 1'b1;
      dm_req    = 1'b1;
      dm_we     = 1'b0;
      mem_rdata = 32'h0;

      // ---- Reset with both requests high -----------------------------
      step();
      step();
      check("rst_mem_en",  32'(mem_en),  32'd0);
      check("rst_mem_we",  32'(mem_we),  32'd0);
      check("rst_mem_sel", 32'(mem_sel), 32'd0);
      check("rst_if_done", 32'(if_done), 32'd0);
      check("rst_dm_done", 32'(dm_done), 32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_rdata",   resp_rdata,   32'h0);
      rst = 1'b0;
      step();
      check("rst_first_en",  32'(mem_en),  32'd1);
      check("rst_first_sel", 32'(mem_sel), 32'd1);
      step();
      step();
      check("rst_first_dm_done", 32'(dm_done), 32'd1);
      if_req = 1'b0;
      dm_req = 1'b0;
      wait_idle("rst_first_idle");

      // ---- Single IF read ---------------------------------------------
      if_req = 1'b1;               // cycle 0
      step();                      // cycle 1
      check("if_en_c1",   32'(mem_en),  32'd1);
      check("if_sel_c1",  32'(mem_sel), 32'd0);
      check("if_we_c1",   32'(mem_we),  32'd0);
      check("if_busy_c1", 32'(busy),    32'd1);
      step();                      // cycle 2
      check("if_en_c2",   32'(mem_en),  32'd0);
      check("if_done_c2", 32'(if_done), 32'd0);
      check("if_busy_c2", 32'(busy),    32'd1);
      step();                      // cycle 3
      mem_rdata = 32'hDEADBEEF;
      #1;
      check("if_done_c3",  32'(if_done), 32'd1);
      check("if_dm_done_c3", 32'(dm_done), 32'd0);
      check("if_rdata_c3", resp_rdata,   32'hDEADBEEF);
      check("if_busy_c3",  32'(busy),    32'd1);
      if_req = 1'b0;
      step();                      // cycle 4
      mem_rdata = 32'h0BAD0BAD;
      #1;
      check("if_busy_c4",  32'(busy),    32'd0);
      check("if_done_c4",  32'(if_done), 32'd0);
      check("if_rdata_hold", resp_rdata, 32'hDEADBEEF);

      // ---- DM write ---------------------------------------------------
      dm_req    = 1'b1;
      dm_we     = 1'b1;
      mem_rdata = 32'h12345678;
      step();                      // cycle 1
      check("wr_sel_c1", 32'(mem_sel), 32'd1);
      check("wr_en_c1",  32'(mem_en),  32'd1);
      check("wr_we_c1",  32'(mem_we),  32'd1);
      step();                      // cycle 2
      check("wr_en_c2",  32'(mem_en),  32'd0);
      check("wr_we_c2",  32'(mem_we),  32'd0);
      check("wr_sel_c2", 32'(mem_sel), 32'd1);
      step();                      // cycle 3
      check("wr_dm_done_c3", 32'(dm_done), 32'd1);
      check("wr_if_done_c3", 32'(if_done), 32'd0);
      check("wr_rdata_held", resp_rdata,   32'hDEADBEEF);
      dm_req = 1'b0;
      dm_we  = 1'b0;
      step();                      // cycle 4
      check("wr_busy_c4",   32'(busy),  resp_rdata == 32'hDEADBEEF ? 32'd0 : 32'd0);
      check("wr_rdata_c4",  resp_rdata, 32'hDEADBEEF);

      // ---- Starvation: both held, grants DM x4, IF, DM ------------------
      if_req = 1'b1;
      dm_req = 1'b1;
      for (int g = 0; g < 6; g++) begin
         wait_mem_en($sformatf("starve_g%0d", g));
         check($sformatf("starve_sel_g%0d", g), 32'(mem_sel), 32'(exp_sel[g]));
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      wait_idle("starve_idle");

      // ---- Reset in second ACCESS cycle of a DM read ----------------------
      dm_req = 1'b1;
      step();                      // cycle 1
      check("rsta_en_c1", 32'(mem_en), 32'd1);
      step();                      // cycle 2, second ACCESS
      check("rsta_busy_c2", 32'(busy), 32'd1);
      rst    = 1'b1;
      dm_req = 1'b0;
      step();
      check("rsta_busy",    32'(busy),    32'd0);
      check("rsta_dm_done", 32'(dm_done), 32'd0);
      check("rsta_sel",     32'(mem_sel), 32'd0);
      rst = 1'b0;
      en_cnt   = 0;
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (mem_en)  en_cnt++;
         if (dm_done) done_cnt++;
      end
      check("rsta_no_en",   32'(en_cnt),   32'd0);
      check("rsta_no_done", 32'(done_cnt), 32'd0);

      // ---- if_req dropped during ACCESS --------------------------------
      if_req = 1'b1;               // cycle 0
      step();                      // cycle 1
      check("drop_en_c1", 32'(mem_en), 32'd1);
      if_req = 1'b0;
      step();                      // cycle 2
      step();                      // cycle 3
      mem_rdata = 32'hCAFEF00D;
      #1;
      check("drop_done_c3",  32'(if_done), 32'd1);
      check("drop_rdata_c3", resp_rdata,   32'hCAFEF00D);
      en_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (mem_en) en_cnt++;
      end
      check("drop_no_en",   32'(en_cnt), 32'd0);
      check("drop_idle",    32'(busy),   32'd0);
      check("drop_rdata_hold", resp_rdata, 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_mem_port_arbiter
